// File: rtl/rand_pulse_sched.sv
// rand_pulse_sched: shares one stretched output pulse channel among N_SRC
// pulse sources. Rising edges on each source are latched as pending
// requests and served round-robin. Each grant produces a fixed-length pulse
// followed by optional dead time. Accepted and dropped events are counted.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   en          scheduler enable (gates edge latching and new grants)
//   src_pulse   level outputs of the pulse generators
//   pulse_len   output pulse length in cycles (0 is treated as 1)
//   dead_len    idle cycles after each pulse (0 = none)
//   cnt_clr     synchronous clear of both counters (wins over increments)
//   pout        stretched output pulse (registered)
//   pout_src    index of the source owning the current/last pulse
//   busy        high while in ACTIVE or DEAD
//   accept_cnt  granted events, saturating
//   drop_cnt    events lost to pile-up on an already pending source, saturating
module rand_pulse_sched #(
  parameter int N_SRC = 4,
  parameter int LEN_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_SRC-1:0]         src_pulse,
  input  logic [LEN_W-1:0]         pulse_len,
  input  logic [LEN_W-1:0]         dead_len,
  input  logic                     cnt_clr,
  output logic                     pout,
  output logic [$clog2(N_SRC)-1:0] pout_src,
  output logic                     busy,
  output logic [CNT_W-1:0]         accept_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, ACTIVE, DEAD} state_t;

  state_t           state;
  logic [N_SRC-1:0] dly;
  logic [N_SRC-1:0] pend;
  logic [IDX_W-1:0] rr_ptr;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] dead_cnt;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] gnt_mask;
  logic [N_SRC-1:0] drop_vec;
  logic             gnt_ok;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W:0]   ndrop;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] acc_next;
  int unsigned      j;

  assign rise = src_pulse & ~dly & {N_SRC{en}};

  // Round-robin search starting just after the last granted index.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    j       = 0;
    if (state == IDLE && en) begin
      for (int unsigned k = 1; k <= N_SRC; k++) begin
        j = (int'(rr_ptr) + k) % N_SRC;
        if (!gnt_ok && pend[j]) begin
          gnt_ok  = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    gnt_mask = '0;
    if (gnt_ok) gnt_mask[gnt_idx] = 1'b1;
  end

  // An edge on a source being granted this cycle re-arms it instead of dropping.
  assign drop_vec = rise & pend & ~gnt_mask;

  always_comb begin
    ndrop = '0;
    for (int unsigned k = 0; k < N_SRC; k++)
      ndrop = ndrop + (CNT_W+1)'(drop_vec[k]);
  end

  assign drop_sum  = {1'b0, drop_cnt} + ndrop;
  assign drop_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  assign acc_next  = (gnt_ok && accept_cnt != '1) ? accept_cnt + 1'b1 : accept_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dly        <= '0;
      pend       <= '0;
      rr_ptr     <= IDX_W'(N_SRC - 1);
      len_cnt    <= '0;
      dead_cnt   <= '0;
      pout       <= 1'b0;
      pout_src   <= '0;
      busy       <= 1'b0;
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      dly  <= src_pulse;
      pend <= (pend & ~gnt_mask) | rise;

      if (cnt_clr) begin
        accept_cnt <= '0;
        drop_cnt   <= '0;
      end else begin
        accept_cnt <= acc_next;
        drop_cnt   <= drop_next;
      end

      case (state)
        IDLE: begin
          if (gnt_ok) begin
            rr_ptr   <= gnt_idx;
            pout_src <= gnt_idx;
            pout     <= 1'b1;
            busy     <= 1'b1;
            len_cnt  <= (pulse_len == '0) ? '0 : pulse_len - 1'b1;
            state    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (len_cnt == '0) begin
            pout <= 1'b0;
            if (dead_len == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              dead_cnt <= dead_len - 1'b1;
              state    <= DEAD;
            end
          end else begin
            len_cnt <= len_cnt - 1'b1;
          end
        end
        DEAD: begin
          if (dead_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            dead_cnt <= dead_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_pulse_sched.sv
// Testbench for rand_pulse_sched: a cycle-by-cycle vector table with
// hand-computed expected outputs, plus hand-written sequences for
// asynchronous reset mid-pulse, drop saturation and counter clear.
module tb_rand_pulse_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] src_pulse;
  logic [4:0] pulse_len;
  logic [4:0] dead_len;
  logic       cnt_clr;
  logic       pout;
  logic [1:0] pout_src;
  logic       busy;
  logic [3:0] accept_cnt;
  logic [3:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  rand_pulse_sched #(.N_SRC(4), .LEN_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .src_pulse(src_pulse),
    .pulse_len(pulse_len), .dead_len(dead_len), .cnt_clr(cnt_clr),
    .pout(pout), .pout_src(pout_src), .busy(busy),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [3:0] src;
    logic [4:0] pl;
    logic [4:0] dl;
    logic       pout;
    logic [1:0] psrc;
    logic       busy;
    int         acc;
    int         drop;
  } vec_t;

  vec_t tbl[$];

  task automatic push(input int n, input logic e, input logic [3:0] s,
                      input logic [4:0] p, input logic [4:0] d,
                      input logic po, input logic [1:0] ps, input logic b,
                      input int a, input int dr);
    vec_t v;
    v.en = e; v.src = s; v.pl = p; v.dl = d;
    v.pout = po; v.psrc = ps; v.busy = b; v.acc = a; v.drop = dr;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int po, input int ps,
                         input int b, input int a, input int dr);
    chk({tag, ".pout"}, int'(pout), po);
    chk({tag, ".pout_src"}, int'(pout_src), ps);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".accept"}, int'(accept_cnt), a);
    chk({tag, ".drop"}, int'(drop_cnt), dr);
  endtask

  initial begin
    // Single event on src2, len 5, no dead time
    push(1, 1, 4'b0100, 5, 0,  0, 2'd0, 0, 0, 0);
    push(5, 1, 4'b0000, 5, 0,  1, 2'd2, 1, 1, 0);
    push(2, 1, 4'b0000, 5, 0,  0, 2'd2, 0, 1, 0);
    // Simultaneous src0/src2, len 3, dead 2
    push(1, 1, 4'b0101, 3, 2,  0, 2'd2, 0, 1, 0);
    push(3, 1, 4'b0000, 3, 2,  1, 2'd0, 1, 2, 0);
    push(2, 1, 4'b0000, 3, 2,  0, 2'd0, 1, 2, 0);
    push(1, 1, 4'b0000, 3, 2,  0, 2'd0, 0, 2, 0);
    push(3, 1, 4'b0000, 3, 2,  1, 2'd2, 1, 3, 0);
    push(2, 1, 4'b0000, 3, 2,  0, 2'd2, 1, 3, 0);
    push(1, 1, 4'b0000, 3, 2,  0, 2'd2, 0, 3, 0);
    // Pair again with len 0 (one cycle), no dead: src0 first, one IDLE gap
    push(1, 1, 4'b0101, 0, 0,  0, 2'd2, 0, 3, 0);
    push(1, 1, 4'b0000, 0, 0,  1, 2'd0, 1, 4, 0);
    push(1, 1, 4'b0000, 0, 0,  0, 2'd0, 0, 4, 0);
    push(1, 1, 4'b0000, 0, 0,  1, 2'd2, 1, 5, 0);
    push(2, 1, 4'b0000, 0, 0,  0, 2'd2, 0, 5, 0);
    // Pile-up on src1 behind a 10-cycle src0 pulse
    push(1, 1, 4'b0001, 10, 0, 0, 2'd2, 0, 5, 0);
    push(1, 1, 4'b0010, 10, 0, 1, 2'd0, 1, 6, 0);
    push(1, 1, 4'b0000, 10, 0, 1, 2'd0, 1, 6, 0);
    push(1, 1, 4'b0010, 10, 0, 1, 2'd0, 1, 6, 1);
    push(7, 1, 4'b0000, 10, 0, 1, 2'd0, 1, 6, 1);
    push(1, 1, 4'b0000, 1, 0,  0, 2'd0, 0, 6, 1);
    // Edge coincident with own grant: re-armed, second pulse, no drop
    push(1, 1, 4'b0010, 1, 0,  1, 2'd1, 1, 7, 1);
    push(1, 1, 4'b0000, 1, 0,  0, 2'd1, 0, 7, 1);
    push(1, 1, 4'b0000, 1, 0,  1, 2'd1, 1, 8, 1);
    push(2, 1, 4'b0000, 1, 0,  0, 2'd1, 0, 8, 1);
    // en=0 during a pulse: pulse completes, new edge ignored
    push(1, 1, 4'b1000, 3, 0,  0, 2'd1, 0, 8, 1);
    push(1, 1, 4'b0000, 3, 0,  1, 2'd3, 1, 9, 1);
    push(1, 0, 4'b0001, 3, 0,  1, 2'd3, 1, 9, 1);
    push(1, 0, 4'b0000, 3, 0,  1, 2'd3, 1, 9, 1);
    push(2, 0, 4'b0000, 3, 0,  0, 2'd3, 0, 9, 1);
    push(1, 1, 4'b0000, 3, 0,  0, 2'd3, 0, 9, 1);

    rst = 1'b1; en = 1'b1; src_pulse = '0; pulse_len = 5'd1;
    dead_len = '0; cnt_clr = 1'b0;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; src_pulse = tbl[i].src;
      pulse_len = tbl[i].pl; dead_len = tbl[i].dl;
      step();
      chk_all($sformatf("v%0d", i), int'(tbl[i].pout), int'(tbl[i].psrc),
              int'(tbl[i].busy), tbl[i].acc, tbl[i].drop);
    end

    // Reset mid-ACTIVE with src1/src2 pending
    en = 1'b1; pulse_len = 5'd10; dead_len = '0;
    src_pulse = 4'b0001; step();
    src_pulse = 4'b0110; step();
    src_pulse = 4'b0000; step();
    chk("pre_rst.pout", int'(pout), 1);
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("post_rst.idle", int'(pout), 0);
    src_pulse = 4'b1000; step();
    chk("post_rst.pend", int'(pout), 0);
    src_pulse = 4'b0000; step();
    chk_all("post_rst.grant", 1, 3, 1, 1, 0);
    begin
      int n = 0;
      while (busy && n < 50) begin step(); n++; end
      chk("busy_wait", int'(busy), 0);
    end
    repeat (3) step();
    chk("no_stale.pout", int'(pout), 0);
    chk("no_stale.accept", int'(accept_cnt), 1);

    // Drop saturation: three sources pile up per edge behind a long pulse
    pulse_len = 5'd31;
    src_pulse = 4'b0001; step();
    src_pulse = 4'b1110; step();
    chk_all("sat.grant", 1, 0, 1, 2, 0);
    for (int k = 1; k <= 6; k++) begin
      src_pulse = 4'b0000; step();
      src_pulse = 4'b1110; step();
      chk($sformatf("sat.drop%0d", k), int'(drop_cnt), (3*k > 15) ? 15 : 3*k);
    end
    src_pulse = 4'b0000; step();
    cnt_clr = 1'b1; src_pulse = 4'b1110; step();
    chk("clr.drop", int'(drop_cnt), 0);
    chk("clr.accept", int'(accept_cnt), 0);
    cnt_clr = 1'b0; src_pulse = 4'b0000; step();
    chk("clr.hold", int'(drop_cnt), 0);
    chk("clr.pout", int'(pout), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
